// File: rtl/chess_game_clock_if.sv
// Bundle between the move-logic block (master) and the chess clock (slave):
// game control inputs going in, seven-segment digits and timeout flags coming out.
interface chess_game_clock_if;
    logic       run;
    logic       halt;
    logic       player;
    logic [6:0] white_mins_seg;
    logic [6:0] white_tens_seg;
    logic [6:0] white_units_seg;
    logic [6:0] black_mins_seg;
    logic [6:0] black_tens_seg;
    logic [6:0] black_units_seg;
    logic       white_timeout;
    logic       black_timeout;

    modport master (
        output run, halt, player,
        input  white_mins_seg, white_tens_seg, white_units_seg,
        input  black_mins_seg, black_tens_seg, black_units_seg,
        input  white_timeout, black_timeout
    );

    modport slave (
        input  run, halt, player,
        output white_mins_seg, white_tens_seg, white_units_seg,
        output black_mins_seg, black_tens_seg, black_units_seg,
        output white_timeout, black_timeout
    );
endinterface

// File: rtl/chess_game_clock.sv
// Two-player chess clock with Fischer increment. Counts the side-to-move's
// remaining seconds down at 1 s resolution, raises sticky timeout flags and
// drives registered active-low M:SS seven-segment digits for both sides.
module chess_game_clock #(
    parameter int CLOCK_FREQ    = 50_000_000,
    parameter int START_MINS    = 5,
    parameter int INCREMENT_SEC = 0
) (
    input  logic              clock,
    input  logic              reset,
    chess_game_clock_if.slave game
);

    localparam int             PW        = (CLOCK_FREQ > 1) ? $clog2(CLOCK_FREQ) : 1;
    localparam logic [PW-1:0]  PRE_MAX   = PW'(CLOCK_FREQ - 1);
    localparam logic [9:0]     MAX_SEC   = 10'd599;
    localparam logic [9:0]     START_SEC = 10'(START_MINS * 60);
    localparam logic [9:0]     INC_SEC   = 10'(INCREMENT_SEC);

    // Active-low 7-segment code, bit0 = a ... bit6 = g.
    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    // Adds the Fischer increment, clamping at 9:59.
    function automatic logic [9:0] add_inc_sat(input logic [9:0] s);
        logic [10:0] sum;
        sum = {1'b0, s} + {1'b0, INC_SEC};
        return (sum > {1'b0, MAX_SEC}) ? MAX_SEC : sum[9:0];
    endfunction

    // Seconds to {mins, tens, units} segment codes.
    function automatic logic [20:0] sec_to_segs(input logic [9:0] s);
        logic [9:0] rem;
        rem = s % 10'd60;
        return {seg7(4'(s / 10'd60)), seg7(4'(rem / 10'd10)), seg7(4'(rem % 10'd10))};
    endfunction

    logic [PW-1:0] pre_q, pre_d;
    logic [9:0]    white_sec_q, white_sec_d;
    logic [9:0]    black_sec_q, black_sec_d;
    logic          player_q, player_d;
    logic          white_to_q, white_to_d;
    logic          black_to_q, black_to_d;

    logic          active, move, tick, expire;
    logic [9:0]    run_sec, new_sec;

    logic [6:0]    white_mins_q, white_tens_q, white_units_q;
    logic [6:0]    black_mins_q, black_tens_q, black_units_q;
    logic [6:0]    white_mins_d, white_tens_d, white_units_d;
    logic [6:0]    black_mins_d, black_tens_d, black_units_d;

    // Prescaler, move detection, decrement-then-increment of the side that was on move.
    always_comb begin
        active      = game.run & ~game.halt & ~white_to_q & ~black_to_q;
        move        = active & (game.player != player_q);
        tick        = active & (pre_q == PRE_MAX);
        pre_d       = pre_q;
        player_d    = player_q;
        white_sec_d = white_sec_q;
        black_sec_d = black_sec_q;
        white_to_d  = white_to_q;
        black_to_d  = black_to_q;
        expire      = 1'b0;

        if (active) begin
            // A move restarts the second so the incoming side gets a full one.
            if (move || tick) begin
                pre_d = '0;
            end else begin
                pre_d = pre_q + 1'b1;
            end
            player_d = game.player;
        end

        // player_q names both the side whose clock is running and, on a move,
        // the side that just moved; both updates therefore land on the same count.
        run_sec = player_q ? white_sec_q : black_sec_q;
        new_sec = run_sec;
        if (tick && (run_sec != 10'd0)) begin
            new_sec = run_sec - 10'd1;
            expire  = (new_sec == 10'd0);
        end
        if (move && !expire) begin
            new_sec = add_inc_sat(new_sec);
        end

        if (player_q) begin
            white_sec_d = new_sec;
            white_to_d  = white_to_q | expire;
        end else begin
            black_sec_d = new_sec;
            black_to_d  = black_to_q | expire;
        end
    end

    // Display digits follow the current counts, shown one cycle later.
    always_comb begin
        {white_mins_d, white_tens_d, white_units_d} = sec_to_segs(white_sec_q);
        {black_mins_d, black_tens_d, black_units_d} = sec_to_segs(black_sec_q);
    end

    // Clock state registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            pre_q       <= '0;
            white_sec_q <= START_SEC;
            black_sec_q <= START_SEC;
            player_q    <= 1'b1;
            white_to_q  <= 1'b0;
            black_to_q  <= 1'b0;
        end else begin
            pre_q       <= pre_d;
            white_sec_q <= white_sec_d;
            black_sec_q <= black_sec_d;
            player_q    <= player_d;
            white_to_q  <= white_to_d;
            black_to_q  <= black_to_d;
        end
    end

    // Registered segment outputs, showing the starting time out of reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            white_mins_q  <= seg7(4'(START_MINS));
            white_tens_q  <= seg7(4'd0);
            white_units_q <= seg7(4'd0);
            black_mins_q  <= seg7(4'(START_MINS));
            black_tens_q  <= seg7(4'd0);
            black_units_q <= seg7(4'd0);
        end else begin
            white_mins_q  <= white_mins_d;
            white_tens_q  <= white_tens_d;
            white_units_q <= white_units_d;
            black_mins_q  <= black_mins_d;
            black_tens_q  <= black_tens_d;
            black_units_q <= black_units_d;
        end
    end

    assign game.white_mins_seg  = white_mins_q;
    assign game.white_tens_seg  = white_tens_q;
    assign game.white_units_seg = white_units_q;
    assign game.black_mins_seg  = black_mins_q;
    assign game.black_tens_seg  = black_tens_q;
    assign game.black_units_seg = black_units_q;
    assign game.white_timeout   = white_to_q;
    assign game.black_timeout   = black_to_q;

endmodule
